add_bit: RTL and testbench

Single-bit full adder with a registered output stage and optional bit-serial carry chaining. Combinational `sum`/`co` are always available with zero latency for ripple-carry use. Registered copies with a valid flag let the block feed pipelined datapaths. When the serial feature is compiled in, the registered carry feeds back so multi-bit operands can be added LSB-first, one bit per clock.

---
 rtl/add_bit_if.sv | 26 ++
 rtl/add_bit.sv | 62 ++++++
 tb/tb_add_bit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/add_bit_if.sv
// Operand, carry-control and result signals of the add_bit full-adder cell.
// The master side drives the operands; the slave side (add_bit) returns the results.
interface add_bit_if;
  logic a;
  logic b;
  logic ci;
  logic in_valid;
  logic ser_en;
  logic ser_start;
  logic sum;
  logic co;
  logic sum_q;
  logic co_q;
  logic out_valid;
  logic carry_q;

  modport master (
    output a, b, ci, in_valid, ser_en, ser_start,
    input  sum, co, sum_q, co_q, out_valid, carry_q
  );

  modport slave (
    input  a, b, ci, in_valid, ser_en, ser_start,
    output sum, co, sum_q, co_q, out_valid, carry_q
  );
endinterface

// File: rtl/add_bit.sv
// Single-bit full adder with combinational and registered results.
// Define ADD_BIT_SERIAL_EN to feed the stored carry back for LSB-first serial addition.
module add_bit (
  input  logic      clk,
  input  logic      rst,
  add_bit_if.slave  bus
);

  logic ci_eff;
  logic sum_next;
  logic co_next;
  logic sum_reg;
  logic co_reg;
  logic carry_reg;
  logic valid_reg;

`ifdef ADD_BIT_SERIAL_EN
  // The stored carry replaces ci on every serial bit except the LSB.
  always_comb begin
    ci_eff = bus.ci;
    if (bus.ser_en && !bus.ser_start) begin
      ci_eff = carry_reg;
    end
  end
`else
  logic unused_ser;
  assign unused_ser = bus.ser_en ^ bus.ser_start;

  always_comb begin
    ci_eff = bus.ci;
  end
`endif

  always_comb begin
    sum_next = bus.a ^ bus.b ^ ci_eff;
    co_next  = (bus.a & bus.b) | (bus.a & ci_eff) | (bus.b & ci_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg   <= 1'b0;
      co_reg    <= 1'b0;
      carry_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        sum_reg   <= sum_next;
        co_reg    <= co_next;
        carry_reg <= co_next;
      end
    end
  end

  assign bus.sum       = sum_next;
  assign bus.co        = co_next;
  assign bus.sum_q     = sum_reg;
  assign bus.co_q      = co_reg;
  assign bus.carry_q   = carry_reg;
  assign bus.out_valid = valid_reg;

endmodule

// File: tb/tb_add_bit.sv
// Directed bench for add_bit: truth table, registered stage, async reset and serial add.
// Serial-mode expectations follow whether ADD_BIT_SERIAL_EN is defined.
module tb_add_bit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  add_bit_if bus ();

  add_bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0b at %0t", tag, got, $time);
    end
  endtask

  task automatic drive(input logic a_i, input logic b_i, input logic ci_i,
                       input logic v_i, input logic st_i);
    bus.a         = a_i;
    bus.b         = b_i;
    bus.ci        = ci_i;
    bus.in_valid  = v_i;
    bus.ser_start = st_i;
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, ".sum_q"},     bus.sum_q,     1'b0);
    check({tag, ".co_q"},      bus.co_q,      1'b0);
    check({tag, ".carry_q"},   bus.carry_q,   1'b0);
    check({tag, ".out_valid"}, bus.out_valid, 1'b0);
  endtask

  // Runs 1011 + 0110 LSB-first; expected per-bit results come from the caller.
  task automatic serial_word(input logic [3:0] exp_sum, input logic [3:0] exp_co,
                             input logic exp_carry);
    logic [3:0] av;
    logic [3:0] bv;
    av = 4'b1011;
    bv = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(av[i], bv[i], 1'b0, 1'b1, (i == 0));
      #1;
      check($sformatf("ser.sum[%0d]", i), bus.sum, exp_sum[i]);
      check($sformatf("ser.co[%0d]", i),  bus.co,  exp_co[i]);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ser.carry_q", bus.carry_q, exp_carry);
  endtask

  initial begin
    logic [4:0]  tt [5];
    logic [3:0]  ser_sum;
    logic [3:0]  ser_co;
    logic        ser_carry;
    checks = 0;
    errors = 0;

    // {a,b,ci,co,sum}
    tt[0] = 5'b000_0_0;
    tt[1] = 5'b100_0_1;
    tt[2] = 5'b110_1_0;
    tt[3] = 5'b111_1_1;
    tt[4] = 5'b011_1_0;

`ifdef ADD_BIT_SERIAL_EN
    ser_sum   = 4'b0001;
    ser_co    = 4'b1110;
    ser_carry = 1'b1;
`else
    ser_sum   = 4'b1101;
    ser_co    = 4'b0010;
    ser_carry = 1'b0;
`endif

    rst        = 1'b1;
    bus.ser_en = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_regs_zero("reset");
    #11 rst = 1'b0;

    // Truth-table walk, registered stage idle
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(tt[i][4], tt[i][3], tt[i][2], 1'b0, 1'b0);
      #5;
      check($sformatf("tt%0d.co", i),  bus.co,  tt[i][1]);
      check($sformatf("tt%0d.sum", i), bus.sum, tt[i][0]);
      check($sformatf("tt%0d.sum_q", i),     bus.sum_q,     1'b0);
      check($sformatf("tt%0d.out_valid", i), bus.out_valid, 1'b0);
    end

    // Registered stage: one valid edge, then hold
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("reg.sum_q",     bus.sum_q,     1'b1);
    check("reg.co_q",      bus.co_q,      1'b1);
    check("reg.out_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("hold.out_valid", bus.out_valid, 1'b0);
    check("hold.sum_q",     bus.sum_q,     1'b1);
    check("hold.co_q",      bus.co_q,      1'b1);
    check("hold.carry_q",   bus.carry_q,   1'b1);

    // Async reset between edges; combinational path unaffected
    #2 rst = 1'b1;
    #1;
    check_regs_zero("arst");
    check("arst.sum", bus.sum, 1'b1);
    check("arst.co",  bus.co,  1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("arst.sum2", bus.sum, 1'b1);
    check("arst.co2",  bus.co,  1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Serial add 1011 + 0110
    bus.ser_en = 1'b1;
    serial_word(ser_sum, ser_co, ser_carry);

    // ser_start without in_valid must not disturb stored state
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("idle_start.carry_q",   bus.carry_q,   ser_carry);
    check("idle_start.out_valid", bus.out_valid, 1'b0);

    // ser_en=0 uses ci even when a carry is stored
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.ser_en = 1'b0;
    #1;
    check("ser_off.sum", bus.sum, 1'b1);
    check("ser_off.co",  bus.co,  1'b0);
    bus.ser_en = 1'b1;

    // Mid-word reset clears the stored carry
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("mid.carry_before", bus.carry_q, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid.carry_rst", bus.carry_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("mid.sum", bus.sum, 1'b1);
    check("mid.co",  bus.co,  1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("mid.sum_q",   bus.sum_q,   1'b1);
    check("mid.carry_q", bus.carry_q, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
